// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: clock rate, bit timing, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

   // System clock frequency the bit timing is derived from.
   localparam int NEXCLK = 100_000_000;

   // Transmit FSM states. PARITY is only entered when parity generation is built in.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Clock cycles per bit time. The divide-by-two-then-double rounding keeps the
   // bit spacing identical to the receiver, which samples at half-bit steps.
   function automatic int bit_cycles(input int brate);
      return 2 * (NEXCLK / brate / 2);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the host handshake and the serialiser, DEPTH x 8.
// Latency: a pushed byte is visible on dout the cycle after the push edge.
// Backpressure: full blocks pushes; pops while empty are ignored.
//
// Ports:
//   CLK, RST  clock, asynchronous active-high reset (pointers and count only)
//   push, din byte write strobe and data
//   pop       advance the read pointer
//   full      DEPTH bytes held
//   empty     no bytes held
//   dout      byte at the read pointer (combinational read)
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic [7:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: count gates every read that matters.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: queues bytes and sends them LSB-first as back-to-back 8N1 frames
// (8E1 when UART_TX_PARITY_EN is defined). Latency: start bit on t two cycles after accept.
// Backpressure: tx_ready = !full, registered occupancy only; tx_valid ignored while full.
//
// Ports:
//   CLK       system clock (NEXCLK)
//   RST       asynchronous active-high reset; aborts any frame, t forced high
//   tx_data   byte to send, qualified by tx_valid
//   tx_valid  tx_data valid; accepted on a rising CLK with tx_ready high
//   tx_ready  FIFO has room
//   t         serial line, idle high
//   T_O       one-cycle pulse on the last cycle of each stop bit
//   busy      frame on the line or bytes queued
//
// Build option: UART_TX_PARITY_EN adds an even-parity bit after bit 7.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int BRate = 9600,
   parameter int DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       t,
   output logic       T_O,
   output logic       busy
);

   localparam int BIT_CYCLES = bit_cycles(BRate);
   localparam int BW         = $clog2(BIT_CYCLES);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);

   tx_state_t     state;
   tx_state_t     state_nxt;
   logic [BW-1:0] baud;
   logic [BW-1:0] baud_nxt;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_nxt;
   logic [7:0]    shift;
   logic [7:0]    shift_nxt;
   logic          bit_end;
   logic          line_nxt;
   logic          pop;
   logic          push;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
`ifdef UART_TX_PARITY_EN
   logic          par;
   logic          par_nxt;
`endif

   //-----------------------------------------------------------------
   // Byte queue
   //-----------------------------------------------------------------
   assign push     = tx_valid && !fifo_full;
   assign tx_ready = !fifo_full;

   uart_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .din   (tx_data),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   //-----------------------------------------------------------------
   // FSM state and datapath registers
   //-----------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         baud    <= baud_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
`ifdef UART_TX_PARITY_EN
         par     <= par_nxt;
`endif
      end
   end

   assign bit_end = (baud == BAUD_LAST);

   //-----------------------------------------------------------------
   // Next state, pop strobe and line value for the current state
   //-----------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      baud_nxt    = bit_end ? '0 : baud + BW'(1);
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      pop         = 1'b0;
      line_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_nxt     = par;
`endif

      case (state)
         IDLE: begin
            baud_nxt    = '0;
            bit_idx_nxt = '0;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_nxt = fifo_dout;
`ifdef UART_TX_PARITY_EN
               par_nxt   = ^fifo_dout;
`endif
               state_nxt = START;
            end
         end

         START: begin
            line_nxt = 1'b0;
            if (bit_end) begin
               bit_idx_nxt = '0;
               state_nxt   = DATA;
            end
         end

         DATA: begin
            line_nxt = shift[0];
            if (bit_end) begin
               shift_nxt = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
         end

         PARITY: begin
`ifdef UART_TX_PARITY_EN
            line_nxt = par;
            if (bit_end) state_nxt = STOP;
`else
            // Unreachable without parity; recover to a clean idle line.
            baud_nxt  = '0;
            state_nxt = IDLE;
`endif
         end

         STOP: begin
            line_nxt = 1'b1;
            if (bit_end) begin
               // Chain straight into the next start bit so queued frames have no gap.
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  shift_nxt = fifo_dout;
`ifdef UART_TX_PARITY_EN
                  par_nxt   = ^fifo_dout;
`endif
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end

         default: begin
            baud_nxt  = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   //-----------------------------------------------------------------
   // Registered outputs. All three lag the FSM state by one cycle, so the
   // whole frame (and T_O) is shifted uniformly and the line never glitches.
   //-----------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         t    <= 1'b1;
         T_O  <= 1'b0;
         busy <= 1'b0;
      end else begin
         t    <= line_nxt;
         T_O  <= (state == STOP) && bit_end;
         busy <= (state != IDLE) || !fifo_empty;
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a 10-cycle bit time.
// Latency: checks start bit two cycles after accept and frame-to-frame spacing.
// Backpressure: checks tx_ready on fill, hold-while-full and reset recovery.
module tb_uart_transmitter;

   localparam int BIT  = 10;   // 2*(100e6/10e6/2)
   localparam int HALF = BIT / 2;

   logic       CLK;
   logic       RST;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       t;
   logic       T_O;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   uart_transmitter #(
      .BRate (10_000_000),
      .DEPTH (4)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .t        (t),
      .T_O      (T_O),
      .busy     (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Entered 'already' cycles after the first start-bit cycle S; returns at S+frame,
   // which is the first start-bit cycle of any following back-to-back frame.
   task automatic frame_check(input logic [7:0] b, input int already, input string tag);
      check({tag, "_start"}, t, 1'b0);
      repeat (HALF - already) tick();
      check({tag, "_start_mid"}, t, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      for (int i = 0; i < 8; i++) begin
         repeat (BIT) tick();
         check($sformatf("%s_d%0d", tag, i), t, b[i]);
      end
`ifdef UART_TX_PARITY_EN
      repeat (BIT) tick();
      check({tag, "_parity"}, t, ^b);
`endif
      repeat (BIT) tick();
      check({tag, "_stop"}, t, 1'b1);
      repeat (HALF - 2) tick();
      check({tag, "_to_early"}, T_O, 1'b0);
      tick();
      check({tag, "_to_pulse"}, T_O, 1'b1);
      check({tag, "_stop_last"}, t, 1'b1);
      tick();
   endtask

   // Push one byte into an idle transmitter and check the whole frame.
   task automatic send_single(input logic [7:0] b, input string tag);
      tx_data  = b;
      tx_valid = 1'b1;
      check({tag, "_ready"}, tx_ready, 1'b1);
      tick();
      tx_valid = 1'b0;
      check({tag, "_lat0"}, t, 1'b1);
      tick();
      check({tag, "_lat1"}, t, 1'b1);
      tick();
      frame_check(b, 0, tag);
      check({tag, "_idle_t"}, t, 1'b1);
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_to"}, T_O, 1'b0);
   endtask

   logic [7:0] burst [5];
   logic [7:0] held  [5];

   initial begin
      RST      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      // Reset state
      #2 RST = 1'b1;
      #2;
      check("rst_t", t, 1'b1);
      check("rst_ready", tx_ready, 1'b1);
      check("rst_to", T_O, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(posedge CLK);
      @(posedge CLK);
      #2 RST = 1'b0;
      tick();

      // Single frame 0xA5: 1,0,1,0,0,1,0,1 LSB first
      send_single(8'hA5, "a5");

      // Five bytes while idle: first pops at once, the other four fill the FIFO
      burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hC3; burst[3] = 8'h5A; burst[4] = 8'hF0;
      for (int i = 0; i < 5; i++) begin
         tx_data  = burst[i];
         tx_valid = 1'b1;
         check($sformatf("burst_ready%0d", i), tx_ready, 1'b1);
         tick();
      end
      tx_valid = 1'b0;
      check("burst_full", tx_ready, 1'b0);
      frame_check(burst[0], 2, "burst0");
      check("burst_ready_after_pop", tx_ready, 1'b1);
      for (int i = 1; i < 5; i++) frame_check(burst[i], 0, $sformatf("burst%0d", i));
      check("burst_end_busy", busy, 1'b0);
      check("burst_end_t", t, 1'b1);

      // Hold tx_valid while full: sixth byte waits for the first pop
      held[0] = 8'h11; held[1] = 8'h22; held[2] = 8'h33; held[3] = 8'h44; held[4] = 8'h55;
      for (int i = 0; i < 5; i++) begin
         tx_data  = held[i];
         tx_valid = 1'b1;
         tick();
      end
      tx_data = 8'h66;
      check("hold_full", tx_ready, 1'b0);
      frame_check(held[0], 2, "hold0");
      // Accepted on the edge right after the pop, so the FIFO is full again.
      check("hold_refill", tx_ready, 1'b0);
      tx_valid = 1'b0;
      for (int i = 1; i < 5; i++) frame_check(held[i], 0, $sformatf("hold%0d", i));
      frame_check(8'h66, 0, "hold5");
      check("hold_end_busy", busy, 1'b0);

      // Reset during data bit 3 of 0xA5 with 0x77 queued behind it
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      tick();
      tx_data  = 8'h77;
      tick();
      tx_valid = 1'b0;
      repeat (1 + 2 * BIT + 2 * BIT + 4) tick();
      check("abort_bit3", t, 1'b0);
      #2 RST = 1'b1;
      #1;
      check("abort_t", t, 1'b1);
      check("abort_ready", tx_ready, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_to", T_O, 1'b0);
      @(posedge CLK);
      #2 RST = 1'b0;
      tick();
      check("abort_rel_t", t, 1'b1);
      check("abort_rel_busy", busy, 1'b0);
      send_single(8'h3C, "post_rst");

      // Edge patterns
      send_single(8'h00, "x00");
      send_single(8'hFF, "xff");
      send_single(8'h07, "x07");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
